decode_seq: RTL and testbench

Registered, handshaked successor to the combinational opcode decoder. Sits between the instruction fetch register and the ALU/register-file stage. Generalises the instruction word to opcode plus a parametrised operand field. Adds skip instructions (DECFSZ, INCFSZ, BTFSC, BTFSS) and the control class (GOTO, CALL), with a state machine that squashes or flushes the instructions that follow them.

---
 rtl/decode_pkg.sv | 64 ++++++
 rtl/decode_table.sv | 90 +++++++++
 rtl/decode_seq.sv | 140 ++++++++++++++
 tb/tb_decode_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the registered opcode decoder.
//   - alu_op codes AluOp0..AluOp15
//   - skip_kind_e: kind of conditional skip an instruction requests
//   - state_e:     sequencer states
//   - instruction class codes taken from opcode bits [7:6]
//   - bundle_t:    decoded control bundle (operand travels separately)
package decode_pkg;

  localparam logic [3:0] AluOp0  = 4'd0;
  localparam logic [3:0] AluOp1  = 4'd1;
  localparam logic [3:0] AluOp2  = 4'd2;
  localparam logic [3:0] AluOp3  = 4'd3;
  localparam logic [3:0] AluOp4  = 4'd4;
  localparam logic [3:0] AluOp5  = 4'd5;
  localparam logic [3:0] AluOp6  = 4'd6;
  localparam logic [3:0] AluOp7  = 4'd7;
  localparam logic [3:0] AluOp8  = 4'd8;
  localparam logic [3:0] AluOp9  = 4'd9;
  localparam logic [3:0] AluOp10 = 4'd10;
  localparam logic [3:0] AluOp11 = 4'd11;
  localparam logic [3:0] AluOp12 = 4'd12;
  localparam logic [3:0] AluOp13 = 4'd13;
  localparam logic [3:0] AluOp14 = 4'd14;
  localparam logic [3:0] AluOp15 = 4'd15;

  typedef enum logic [1:0] {
    SkipNone   = 2'd0,
    SkipZero   = 2'd1,
    SkipBitClr = 2'd2,
    SkipBitSet = 2'd3
  } skip_kind_e;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StWaitCond = 2'd1,
    StSquash   = 2'd2,
    StFlush    = 2'd3
  } state_e;

  localparam logic [1:0] ClsByte = 2'b00;
  localparam logic [1:0] ClsBit  = 2'b01;
  localparam logic [1:0] ClsCtrl = 2'b10;
  localparam logic [1:0] ClsLit  = 2'b11;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       d;
    logic       switch_a_m;
    logic       wr_en;
    logic [2:0] bit_number;
    logic [1:0] skip_kind;
    logic       is_branch;
    logic       is_call;
  } bundle_t;

  // Idle bundle: everything zero except alu_op, which idles at 1.
  function automatic bundle_t reset_bundle();
    bundle_t b;
    b        = '0;
    b.alu_op = AluOp1;
    return b;
  endfunction

endpackage

// File: rtl/decode_table.sv
// decode_table: purely combinational opcode byte -> control bundle mapping.
// Ports:
//   i_op     in  8 : opcode byte
//   o_bundle out   : decoded bundle (bundle_t)
// Build option DECODE_SKIP_EN: when defined, DECFSZ/INCFSZ/BTFSC/BTFSS report a
// skip_kind; otherwise they decode as DECF/INCF/NOP/NOP.
module decode_table
  import decode_pkg::*;
(
  input  logic [7:0] i_op,
  output bundle_t    o_bundle
);

  logic w_unused_op0;
  assign w_unused_op0 = i_op[0];

  always_comb begin
    o_bundle            = reset_bundle();
    o_bundle.bit_number = i_op[3:1];
    unique case (i_op[7:6])
      ClsByte: begin
        o_bundle.d          = i_op[1];
        o_bundle.switch_a_m = 1'b1;
        o_bundle.wr_en      = 1'b1;
        case (i_op[5:2])
          4'b0111: o_bundle.alu_op = AluOp2;
          4'b0101: o_bundle.alu_op = AluOp4;
          4'b0001: o_bundle.alu_op = AluOp9;
          4'b1001: o_bundle.alu_op = AluOp12;
          4'b0011: o_bundle.alu_op = AluOp6;
          4'b1010: o_bundle.alu_op = AluOp5;
          4'b0100: o_bundle.alu_op = AluOp10;
          4'b1000: o_bundle.alu_op = AluOp0;
          4'b1101: o_bundle.alu_op = AluOp8;
          4'b1100: o_bundle.alu_op = AluOp15;
          4'b0010: o_bundle.alu_op = AluOp3;
          4'b1110: o_bundle.alu_op = AluOp11;
          4'b0110: o_bundle.alu_op = AluOp7;
          4'b1011: begin
            o_bundle.alu_op = AluOp6;
`ifdef DECODE_SKIP_EN
            o_bundle.skip_kind = SkipZero;
`endif
          end
          4'b1111: begin
            o_bundle.alu_op = AluOp5;
`ifdef DECODE_SKIP_EN
            o_bundle.skip_kind = SkipZero;
`endif
          end
          default: o_bundle.alu_op = AluOp1;
        endcase
      end
      ClsBit: begin
        o_bundle.d          = 1'b1;
        o_bundle.switch_a_m = 1'b1;
        if (!i_op[5]) begin
          o_bundle.wr_en  = 1'b1;
          o_bundle.alu_op = i_op[4] ? AluOp13 : AluOp14;
        end else begin
          // Bit tests never write back.
          o_bundle.wr_en = 1'b0;
`ifdef DECODE_SKIP_EN
          o_bundle.alu_op    = AluOp0;
          o_bundle.skip_kind = i_op[4] ? SkipBitSet : SkipBitClr;
`else
          o_bundle.alu_op = AluOp1;
`endif
        end
      end
      ClsLit: begin
        o_bundle.wr_en = 1'b1;
        casez (i_op[5:2])
          4'b00??: o_bundle.alu_op = AluOp0;
          4'b1000: o_bundle.alu_op = AluOp10;
          4'b1001: o_bundle.alu_op = AluOp4;
          4'b1010: o_bundle.alu_op = AluOp7;
          4'b110?: o_bundle.alu_op = AluOp3;
          4'b111?: o_bundle.alu_op = AluOp2;
          default: o_bundle.alu_op = AluOp1;
        endcase
      end
      ClsCtrl: begin
        o_bundle.is_branch = 1'b1;
        o_bundle.is_call   = ~i_op[5];
      end
    endcase
  end

endmodule

// File: rtl/decode_seq.sv
// decode_seq: registered, valid/ready handshaked instruction decoder with a
// sequencer that squashes the instruction after a taken skip and flushes
// FLUSH_N instructions after a GOTO/CALL.
// Ports:
//   clk, reset (sync, active-high)
//   in_valid/in_ready/inst        : instruction input handshake
//   out_valid/out_ready           : decoded bundle output handshake
//   alu_op, d, switch_a_m, wr_en, bit_number, operand, skip_kind,
//   is_branch, is_call            : registered decoded bundle
//   skip_valid/skip_take          : skip resolution from execute
// Build option DECODE_SKIP_EN: enables skip decoding and the WAIT_COND/SQUASH
// states; without it skip_valid/skip_take are ignored.
module decode_seq
  import decode_pkg::*;
#(
  parameter int unsigned INST_W  = 16,
  parameter int unsigned FLUSH_N = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic              d,
  output logic              switch_a_m,
  output logic              wr_en,
  output logic [2:0]        bit_number,
  output logic [INST_W-9:0] operand,
  output logic [1:0]        skip_kind,
  output logic              is_branch,
  output logic              is_call,
  input  logic              skip_valid,
  input  logic              skip_take
);

  localparam int unsigned CntW = (FLUSH_N > 0) ? $clog2(FLUSH_N + 1) : 1;

  bundle_t           w_dec;
  bundle_t           r_bundle;
  logic [INST_W-9:0] r_operand;
  logic              r_out_valid;
  state_e            r_state;
  state_e            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;

`ifndef DECODE_SKIP_EN
  logic w_unused_skip;
  assign w_unused_skip = skip_valid ^ skip_take;
`endif

  decode_table u_decode_table (
    .i_op     (inst[INST_W-1 -: 8]),
    .o_bundle (w_dec)
  );

  assign w_in_ready = (~r_out_valid | out_ready) & (r_state != StWaitCond);
  assign w_accept   = in_valid & w_in_ready;
  // Only instructions accepted in RUN reach the output; SQUASH/FLUSH drop them.
  assign w_emit     = w_accept & (r_state == StRun);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StRun: begin
        if (w_accept && w_dec.is_branch && (FLUSH_N > 0)) begin
          w_state_next = StFlush;
          w_cnt_next   = CntW'(FLUSH_N);
        end
`ifdef DECODE_SKIP_EN
        if (w_accept && (w_dec.skip_kind != SkipNone)) begin
          w_state_next = StWaitCond;
        end
`endif
      end
      StWaitCond: begin
`ifdef DECODE_SKIP_EN
        if (skip_valid) begin
          w_state_next = skip_take ? StSquash : StRun;
        end
`else
        w_state_next = StRun;
`endif
      end
      StSquash: begin
        if (w_accept) begin
          w_state_next = StRun;
        end
      end
      StFlush: begin
        if (w_accept) begin
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == CntW'(1)) begin
            w_state_next = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bundle    <= reset_bundle();
      r_operand   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_bundle    <= w_dec;
        r_operand   <= inst[INST_W-9:0];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_op     = r_bundle.alu_op;
  assign d          = r_bundle.d;
  assign switch_a_m = r_bundle.switch_a_m;
  assign wr_en      = r_bundle.wr_en;
  assign bit_number = r_bundle.bit_number;
  assign operand    = r_operand;
  assign skip_kind  = r_bundle.skip_kind;
  assign is_branch  = r_bundle.is_branch;
  assign is_call    = r_bundle.is_call;

endmodule

// File: tb/tb_decode_seq.sv
// tb_decode_seq: directed test-plan sequences plus randomized traffic, checked
// cycle by cycle against a behavioural model of the decoder and sequencer.
module tb_decode_seq;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned FLUSH_N = 2;
`ifdef DECODE_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alu_op;
  logic              d;
  logic              switch_a_m;
  logic              wr_en;
  logic [2:0]        bit_number;
  logic [INST_W-9:0] operand;
  logic [1:0]        skip_kind;
  logic              is_branch;
  logic              is_call;
  logic              skip_valid;
  logic              skip_take;

  decode_seq #(
    .INST_W  (INST_W),
    .FLUSH_N (FLUSH_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .d          (d),
    .switch_a_m (switch_a_m),
    .wr_en      (wr_en),
    .bit_number (bit_number),
    .operand    (operand),
    .skip_kind  (skip_kind),
    .is_branch  (is_branch),
    .is_call    (is_call),
    .skip_valid (skip_valid),
    .skip_take  (skip_take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bundle layout {alu_op, d, switch_a_m, wr_en, bit_number, operand, skip_kind, is_branch, is_call}
  logic [21:0] dut_bundle;
  assign dut_bundle = {alu_op, d, switch_a_m, wr_en, bit_number, operand, skip_kind,
                       is_branch, is_call};

  localparam logic [21:0] RstBundle = {4'd1, 18'd0};

  // Opcode[5:2] -> alu_op lookup per class.
  int byte_alu [16] = '{1, 9, 3, 6, 10, 4, 7, 2, 0, 12, 5, 6, 15, 8, 11, 5};
  int lit_alu  [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 10, 4, 7, 1, 3, 3, 2, 2};

  function automatic logic [21:0] ref_decode(input logic [15:0] w);
    logic [7:0] op;
    int         code, alu, sk;
    bit         dd, sw, we, br, call;
    op = w[15:8];
    code = int'(op[5:2]);
    alu = 1; dd = 0; sw = 0; we = 0; sk = 0; br = 0; call = 0;
    if (op[7:6] == 2'b00) begin
      dd = op[1]; sw = 1; we = 1; alu = byte_alu[code];
      if (SkipEn && (code == 11 || code == 15)) sk = 1;
    end else if (op[7:6] == 2'b01) begin
      dd = 1; sw = 1;
      if (code < 4)       begin alu = 14; we = 1; end
      else if (code < 8)  begin alu = 13; we = 1; end
      else if (SkipEn)    begin alu = 0;  sk = (code < 12) ? 2 : 3; end
    end else if (op[7:6] == 2'b11) begin
      we = 1; alu = lit_alu[code];
    end else begin
      br = 1; call = (code < 8);
    end
    return {alu[3:0], dd, sw, we, op[3:1], w[7:0], sk[1:0], br, call};
  endfunction

  // Behavioural model state.
  bit          m_valid;
  logic [21:0] m_bundle;
  bit          m_wait;
  bit          m_squash;
  int          m_flush;

  function automatic bit m_ready(input bit ordy);
    return (!m_valid || ordy) && !m_wait;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_bundle = RstBundle; m_wait = 0; m_squash = 0; m_flush = 0;
  endtask

  task automatic model_step(input bit rst, input bit iv, input logic [15:0] w,
                            input bit ordy, input bit sv, input bit st);
    bit          acc, emit;
    logic [21:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    acc = iv && m_ready(ordy);
    emit = 0;
    if (m_wait && sv) begin
      m_wait = 0;
      m_squash = st;
    end
    if (acc) begin
      if (m_flush > 0) m_flush--;
      else if (m_squash) m_squash = 0;
      else emit = 1;
    end
    if (emit) begin
      b = ref_decode(w);
      m_valid = 1;
      m_bundle = b;
      if (b[3:2] != 2'd0) m_wait = 1;
      else if (b[1] && FLUSH_N > 0) m_flush = FLUSH_N;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model at posedge.
  task automatic cyc(input bit rst, input bit iv, input logic [15:0] w,
                     input bit ordy, input bit sv, input bit st);
    reset = rst; in_valid = iv; inst = w; out_ready = ordy;
    skip_valid = sv; skip_take = st;
    @(negedge clk);
    check_eq("in_ready", 32'(in_ready), 32'(m_ready(ordy)));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) check_eq("bundle", 32'(dut_bundle), 32'(m_bundle));
    @(posedge clk);
    model_step(rst, iv, w, ordy, sv, st);
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; inst = '0; out_ready = 1; skip_valid = 0; skip_take = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_bundle", 32'(dut_bundle), 32'(RstBundle));

    // Two-instruction stream.
    cyc(0, 1, 16'h1E00, 1, 0, 0);
    check_eq("tp1_alu", 32'(alu_op), 32'd2);
    check_eq("tp1_d", 32'(d), 32'd1);
    check_eq("tp1_sw", 32'(switch_a_m), 32'd1);
    cyc(0, 1, 16'hC0AB, 1, 0, 0);
    check_eq("tp2_alu", 32'(alu_op), 32'd0);
    check_eq("tp2_operand", 32'(operand), 32'hAB);
    check_eq("tp2_d_sw", 32'({d, switch_a_m}), 32'd0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // DECFSZ, taken skip squashes the following ADDWF.
    cyc(0, 1, 16'h2E10, 1, 0, 0);
    check_eq("decfsz_alu", 32'(alu_op), 32'd6);
    check_eq("decfsz_skip", 32'(skip_kind), SkipEn ? 32'd1 : 32'd0);
    cyc(0, 1, 16'h1C22, 1, 0, 0);
    cyc(0, 1, 16'h1C22, 1, 1, 1);
    cyc(0, 1, 16'h1C22, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // BTFSS, skip not taken; next instruction emitted.
    cyc(0, 1, 16'h7A05, 1, 0, 0);
    check_eq("btfss_bit", 32'(bit_number), 32'd5);
    check_eq("btfss_skip", 32'(skip_kind), SkipEn ? 32'd3 : 32'd0);
    check_eq("btfss_wr", 32'(wr_en), 32'd0);
    cyc(0, 1, 16'h1C22, 1, 1, 0);
    cyc(0, 1, 16'h1C22, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // GOTO then three ANDLW; first two are flushed.
    cyc(0, 1, 16'hA012, 1, 0, 0);
    check_eq("goto_branch", 32'({is_branch, is_call}), 32'b10);
    cyc(0, 1, 16'hE401, 1, 0, 0);
    cyc(0, 1, 16'hE402, 1, 0, 0);
    cyc(0, 1, 16'hE403, 1, 0, 0);
    check_eq("andlw3_operand", 32'(operand), 32'h03);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // Downstream stall for three cycles.
    cyc(0, 1, 16'h0C33, 1, 0, 0);
    cyc(0, 1, 16'h1444, 0, 0, 0);
    cyc(0, 1, 16'h1444, 0, 0, 0);
    cyc(0, 1, 16'h1444, 0, 0, 0);
    cyc(0, 1, 16'h1444, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // Reset while waiting on a skip; later skip_valid is ignored.
    cyc(0, 1, 16'h2E10, 1, 0, 0);
    cyc(1, 0, 16'h0000, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 1, 1);
    cyc(0, 1, 16'h1C22, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
